register_c0_d0: RTL and testbench
=================================

REGISTER_C0_D0 -- requirements
Module: register_c0_d0

Interface
REQ-001 SHALL have parameter HALF_W, default 28, giving the width of each key half (C and D) of the DES-style key schedule.
REQ-002 SHALL have parameter RESET_VAL, default all-zero (HALF_W bits), giving the value both outputs take on reset.
REQ-003 SHALL have port Clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port C0, input, HALF_W bits, the C half from permuted choice 1.
REQ-006 SHALL have port D0, input, HALF_W bits, the D half from permuted choice 1.
REQ-007 SHALL have port C0_out, output, HALF_W bits, the registered C half.
REQ-008 SHALL have port D0_out, output, HALF_W bits, the registered D half.
REQ-009 SHALL have no other ports; the block is bound by named connection to exactly these six.

Function
REQ-010 SHALL capture C0 into C0_out and D0 into D0_out on every rising Clk edge where Reset=0.
- Latency is exactly 1 cycle.
- No enable: the block loads every cycle.
REQ-011 SHALL hold C0_out and D0_out constant between rising edges.
- Input changes between edges, including changes just after an edge, have no effect until the next edge.
REQ-012 SHALL update C0_out and D0_out from the same edge; the two halves are never skewed relative to each other.
REQ-013 SHALL pass each bit through unchanged.
- No rotation, permutation or inversion; bit i of C0 maps to bit i of C0_out (same for D).
- Bit HALF_W-1 is the MSB.
REQ-014 SHALL keep outputs purely registered; no combinational path from C0, D0 or Reset to any output.
REQ-015 SHALL give Reset priority over data: an edge with Reset=1 loads RESET_VAL regardless of C0/D0, including X/unknown inputs.
REQ-016 SHALL resume loading C0/D0 on the first rising edge after Reset returns to 0, with no extra idle cycle.
REQ-017 SHALL leave outputs unspecified before the first rising edge with Reset=1; no power-on initial value is relied on.

Reset
REQ-018 SHALL reset only on a rising Clk edge while Reset=1; Reset asserting or deasserting between edges has no immediate effect on the outputs.
REQ-019 SHALL set both C0_out and D0_out to RESET_VAL (0x0000000 at default) on reset.
REQ-020 SHALL accept Reset asserted mid-operation: the next edge clears both outputs, discarding the data present at that edge.

Structure
REQ-021 SHALL take the key-half width constant (28) and the reset value from the shared DES key-schedule package, which is also used by the shift/PC-2 stages.
REQ-022 SHALL instantiate one generic sub-module, des_half_reg (HALF_W-wide register with synchronous active-high reset), twice: once for C, once for D.

Verification
REQ-023 Reset=1 for one edge, C0/D0=X -> C0_out=0x0000000, D0_out=0x0000000.
REQ-024 Reset=0, C0=0x00000FF, D0=0x00001FC applied after an edge -> on the next edge C0_out=0x00000FF, D0_out=0x00001FC.
REQ-025 Following cycle, C0=0x00000CB, D0=0x00231FC -> one edge later C0_out=0x00000CB, D0_out=0x00231FC, and the previous values are held until that edge.
REQ-026 C0=0xFFFFFFF, D0=0xAAAAAAA loaded, then Reset=1 -> that edge gives both outputs 0; with Reset=0 and C0=0x5555555 the next edge gives C0_out=0x5555555.
REQ-027 C0 toggled 0x1234567 -> 0x7654321 -> 0x1234567 entirely between two edges -> outputs do not change until the edge, then take 0x1234567.
REQ-028 C0=0x8000001, D0=0x0000001 -> outputs show identical bit positions; no shift or swap of the halves.

Source files
------------

// File: rtl/register_c0_d0_pkg.sv
// Shared DES key-schedule constants: key-half width and the value
// the C/D registers take on reset. Also used by the shift/PC-2 stages.
package register_c0_d0_pkg;

  localparam int KEY_HALF_W = 28;
  localparam logic [KEY_HALF_W-1:0] KEY_HALF_RESET = '0;

  // Pack C and D into one word, C in the upper half.
  function automatic logic [2*KEY_HALF_W-1:0] pack_cd(
    input logic [KEY_HALF_W-1:0] c,
    input logic [KEY_HALF_W-1:0] d
  );
    return {c, d};
  endfunction

endpackage

// File: rtl/des_half_reg.sv
// Generic key-half register: loads every edge, synchronous active-high reset.
module des_half_reg #(
  parameter int             W       = 28,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Reset wins over data, so unknown data during reset never reaches q.
  always_ff @(posedge Clk) begin
    if (Reset) q <= RST_VAL;
    else       q <= d;
  end

endmodule

// File: rtl/register_c0_d0.sv
// Registers the C0/D0 halves coming out of permuted choice 1; both halves
// share one clock and reset, so they always move on the same edge.
module register_c0_d0
  import register_c0_d0_pkg::*;
#(
  parameter int                HALF_W    = KEY_HALF_W,
  parameter logic [HALF_W-1:0] RESET_VAL = HALF_W'(KEY_HALF_RESET)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [HALF_W-1:0] C0,
  input  logic [HALF_W-1:0] D0,
  output logic [HALF_W-1:0] C0_out,
  output logic [HALF_W-1:0] D0_out
);

  des_half_reg #(
    .W       (HALF_W),
    .RST_VAL (RESET_VAL)
  ) u_c_reg (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (C0),
    .q     (C0_out)
  );

  des_half_reg #(
    .W       (HALF_W),
    .RST_VAL (RESET_VAL)
  ) u_d_reg (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (D0),
    .q     (D0_out)
  );

endmodule

// File: tb/tb_register_c0_d0.sv
// Bench for register_c0_d0: directed key-half cases plus random traffic
// checked every cycle against a one-edge-delay reference model.
module tb_register_c0_d0;

  localparam int W = 28;
  localparam logic [W-1:0] RST = '0;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [W-1:0] C0, D0;
  logic [W-1:0] C0_out, D0_out;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;
  logic [2*W-1:0] exp_q[$];

  register_c0_d0 dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .C0     (C0),
    .D0     (D0),
    .C0_out (C0_out),
    .D0_out (D0_out)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  initial begin
    Reset = 1'b0;
    C0    = 'x;
    D0    = 'x;
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Apply new inputs 1ns after an edge; they are captured by the following edge.
  task automatic step(input logic r, input logic [W-1:0] c, input logic [W-1:0] d);
    @(posedge Clk);
    #1;
    Reset = r;
    C0    = c;
    D0    = d;
  endtask

  task automatic expect_next(input string name, input logic [W-1:0] c, input logic [W-1:0] d);
    @(posedge Clk);
    #2;
    check({name, "_c"}, C0_out, c);
    check({name, "_d"}, D0_out, d);
  endtask

  // ---------------- reference model ----------------
  // Output after an edge is whatever the inputs were at that edge, or the
  // reset value when Reset was high. Undefined until the first reset edge.
  always @(posedge Clk) begin
    if (Reset === 1'b1) check_en = 1'b1;
    if (check_en) begin
      if (Reset === 1'b1) exp_q.push_back({RST, RST});
      else                exp_q.push_back({C0, D0});
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge Clk) begin
    logic [2*W-1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("sb_c", C0_out, e[2*W-1:W]);
      check("sb_d", D0_out, e[W-1:0]);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] rc, rd;

    // Reset with unknown data
    step(1'b1, 'x, 'x);
    expect_next("rst_x", 28'h0000000, 28'h0000000);

    // First load after reset, no idle cycle
    step(1'b0, 28'h00000FF, 28'h00001FC);
    expect_next("load1", 28'h00000FF, 28'h00001FC);

    // New data held off until the next edge
    step(1'b0, 28'h00000CB, 28'h00231FC);
    #1;
    check("hold_c", C0_out, 28'h00000FF);
    check("hold_d", D0_out, 28'h00001FC);
    expect_next("load2", 28'h00000CB, 28'h00231FC);

    // Mid-operation reset discards data, then resume
    step(1'b0, 28'hFFFFFFF, 28'hAAAAAAA);
    expect_next("allones", 28'hFFFFFFF, 28'hAAAAAAA);
    step(1'b1, 28'hFFFFFFF, 28'hAAAAAAA);
    expect_next("midrst", 28'h0000000, 28'h0000000);
    step(1'b0, 28'h5555555, 28'h0000000);
    expect_next("resume", 28'h5555555, 28'h0000000);

    // Glitching input between edges has no effect until the edge
    step(1'b0, 28'h1234567, 28'h0000000);
    #1 C0 = 28'h7654321;
    #1 C0 = 28'h1234567;
    #1;
    check("glitch_hold", C0_out, 28'h5555555);
    expect_next("glitch", 28'h1234567, 28'h0000000);

    // Bit positions preserved, halves not swapped
    step(1'b0, 28'h8000001, 28'h0000001);
    expect_next("bitpos", 28'h8000001, 28'h0000001);

    // Reset asserted between edges has no immediate effect
    @(posedge Clk);
    #1 Reset = 1'b1;
    #2;
    check("async_rst_c", C0_out, 28'h8000001);
    expect_next("rst_edge", 28'h0000000, 28'h0000000);

    // Randomized traffic checked by the scoreboard
    for (int i = 0; i < 400; i++) begin
      rc = W'($urandom);
      rd = W'($urandom);
      step(($urandom_range(0, 9) == 0), rc, rd);
    end

    step(1'b0, 28'h0000000, 28'h0000000);
    @(posedge Clk);
    @(negedge Clk);
    @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
